// File: rtl/auth_pkg.sv
// auth_pkg
// Shared definitions for the authentication command transmitter:
//   - CMD_GO / CMD_STOP : the two command bytes ('G' connect, 'S' disconnect)
//   - BAUD_DIV_DEFAULT  : clocks per UART bit (9600 baud at 50 MHz)
//   - BAUD_CNT_W        : width of the baud counter
//   - tx_state_t        : serializer bit-phase states
//   - ctl_state_t       : command-level phases (idle / frame in flight / gap)
package auth_pkg;

    localparam logic [7:0] CMD_GO           = 8'h47;
    localparam logic [7:0] CMD_STOP         = 8'h53;
    localparam int         BAUD_DIV_DEFAULT = 5208;
    localparam int         BAUD_CNT_W       = 13;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } tx_state_t;

    typedef enum logic [1:0] {
        CTL_IDLE,
        CTL_FRAME,
        CTL_GAP
    } ctl_state_t;

endpackage

// File: rtl/auth_uart_ser.sv
// auth_uart_ser
// 8N1 UART serializer: baud counter, shift register and bit counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : accept data_in and start a frame (honoured only when idle)
//   data_in    : byte to send, LSB first
//   tx_done    : high on the last clock of the stop bit
//   TX         : serial line, idle high
module auth_uart_ser
    import auth_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic       tx_done,
    output logic       TX
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_DIV - 1);

    tx_state_t             state, state_nx;
    logic [BAUD_CNT_W-1:0] baud_cnt, baud_nx;
    logic [2:0]            bit_cnt, bit_nx;
    logic [7:0]            shreg, shreg_nx;
    logic                  baud_roll;

    assign baud_roll = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= 8'hFF;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_cnt  <= bit_nx;
            shreg    <= shreg_nx;
        end
    end

    // The baud counter restarts from zero on every state change so each
    // bit lasts exactly BAUD_DIV clocks.
    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt + BAUD_CNT_W'(1);
        bit_nx   = bit_cnt;
        shreg_nx = shreg;
        tx_done  = 1'b0;
        TX       = 1'b1;
        case (state)
            IDLE: begin
                baud_nx = '0;
                if (load) begin
                    state_nx = START;
                    shreg_nx = data_in;
                    bit_nx   = '0;
                end
            end
            START: begin
                TX = 1'b0;
                if (baud_roll) begin
                    state_nx = DATA;
                    baud_nx  = '0;
                end
            end
            DATA: begin
                TX = shreg[0];
                if (baud_roll) begin
                    baud_nx  = '0;
                    shreg_nx = {1'b1, shreg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        bit_nx = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_roll) begin
                    state_nx = IDLE;
                    baud_nx  = '0;
                    tx_done  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                baud_nx  = '0;
            end
        endcase
    end

endmodule

// File: rtl/auth_cmd_tx.sv
// auth_cmd_tx
// Turns connect/disconnect request pulses into UART command frames
// ('G' = connect, 'S' = disconnect) with disconnect-first arbitration,
// duplicate filtering, an inter-frame gap and link-state tracking.
// Optional macro AUTH_HEARTBEAT_EN adds a periodic heartbeat 'G' while
// connected (parameter HB_PERIOD exists only in that build).
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   connect_req    : one-cycle pulse requesting 'G'
//   disconnect_req : one-cycle pulse requesting 'S'
//   TX             : UART line, idle high
//   busy           : a request is pending or a frame/gap is in progress
//   cmd_done       : one-cycle pulse on the last clock of each stop bit
//   connected      : link state as seen by this end
module auth_cmd_tx
    import auth_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int GAP_BITS = 2
`ifdef AUTH_HEARTBEAT_EN
    ,
    parameter logic [23:0] HB_PERIOD = 24'd5_000_000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic connect_req,
    input  logic disconnect_req,
    output logic TX,
    output logic busy,
    output logic cmd_done,
    output logic connected
);

    localparam int                GAP_CLKS = GAP_BITS * BAUD_DIV;
    localparam int                GAP_W    = $clog2(GAP_CLKS + 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CLKS - 1);

    ctl_state_t       ctl, ctl_nx;
    logic [GAP_W-1:0] gap_cnt, gap_nx;
    logic             pend_g, pend_g_nx;
    logic             pend_s, pend_s_nx;
    logic             conn_q;
    logic             cur_is_go;
    logic             load;
    logic             tx_done;
    logic             hb_fire;
    logic             g_in_flight;
    logic [7:0]       ser_data;

    assign ser_data = pend_s ? CMD_STOP : CMD_GO;

    auth_uart_ser #(
        .BAUD_DIV(BAUD_DIV)
    ) u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .data_in (ser_data),
        .tx_done (tx_done),
        .TX      (TX)
    );

    // The link state flips in the very cycle the stop bit completes, so
    // the output bypasses the register during the cmd_done cycle.
    assign cmd_done    = tx_done;
    assign connected   = tx_done ? cur_is_go : conn_q;
    assign busy        = (ctl != CTL_IDLE) || pend_g || pend_s;
    assign g_in_flight = (ctl == CTL_FRAME) && cur_is_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl       <= CTL_IDLE;
            gap_cnt   <= '0;
            pend_g    <= 1'b0;
            pend_s    <= 1'b0;
            conn_q    <= 1'b0;
            cur_is_go <= 1'b0;
        end else begin
            ctl     <= ctl_nx;
            gap_cnt <= gap_nx;
            pend_g  <= pend_g_nx;
            pend_s  <= pend_s_nx;
            conn_q  <= connected;
            if (load) begin
                cur_is_go <= !pend_s;
            end
        end
    end

    // A request waiting at the end of the gap is launched on the last gap
    // clock, so back-to-back frames are separated by exactly the gap.
    always_comb begin
        ctl_nx = ctl;
        gap_nx = gap_cnt;
        load   = 1'b0;
        case (ctl)
            CTL_IDLE: begin
                if (pend_s || pend_g) begin
                    load   = 1'b1;
                    ctl_nx = CTL_FRAME;
                end
            end
            CTL_FRAME: begin
                if (tx_done) begin
                    ctl_nx = CTL_GAP;
                    gap_nx = '0;
                end
            end
            CTL_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_nx = '0;
                    if (pend_s || pend_g) begin
                        load   = 1'b1;
                        ctl_nx = CTL_FRAME;
                    end else begin
                        ctl_nx = CTL_IDLE;
                    end
                end else begin
                    gap_nx = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                ctl_nx = CTL_IDLE;
                gap_nx = '0;
            end
        endcase
    end

    // Disconnect always wins: it wipes any pending 'G' and blocks new ones.
    // An 'S' is only worth sending if the link is up or about to come up.
    always_comb begin
        pend_s_nx = pend_s;
        pend_g_nx = pend_g;
        if (load) begin
            if (pend_s) begin
                pend_s_nx = 1'b0;
            end else begin
                pend_g_nx = 1'b0;
            end
        end
        if (disconnect_req) begin
            pend_g_nx = 1'b0;
            if (connected || g_in_flight) begin
                pend_s_nx = 1'b1;
            end
        end else if (connect_req && !pend_s && !connected) begin
            pend_g_nx = 1'b1;
        end else if (hb_fire && !pend_s) begin
            pend_g_nx = 1'b1;
        end
    end

`ifdef AUTH_HEARTBEAT_EN
    localparam logic [23:0] HB_LAST = HB_PERIOD - 24'd1;

    logic [23:0] hb_cnt;

    assign hb_fire = connected && !pend_s && !load && (hb_cnt == HB_LAST);

    // Heartbeat timer: runs while the link is up and no 'S' is waiting,
    // restarts on every frame launch and whenever the link is down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt <= '0;
        end else if (!connected || load) begin
            hb_cnt <= '0;
        end else if (!pend_s) begin
            if (hb_cnt == HB_LAST) begin
                hb_cnt <= '0;
            end else begin
                hb_cnt <= hb_cnt + 24'd1;
            end
        end
    end
`else
    assign hb_fire = 1'b0;
`endif

endmodule
